// File: rtl/hbridge_seq_pkg.sv
// Shared definitions for the H-bridge sequencer: FSM states and driver command encodings.
// Both the FSM and the driver-output register map states to commands through igbt_of().
package hbridge_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_POS    = 3'd1,
      ST_DEAD_P = 3'd2,
      ST_NEG    = 3'd3,
      ST_DEAD_N = 3'd4,
      ST_FAULT  = 3'd5
   } state_t;

   localparam logic [1:0] IGBT_OFF = 2'b00;
   localparam logic [1:0] IGBT_R   = 2'b01;
   localparam logic [1:0] IGBT_L   = 2'b10;

   // 11 is unreachable: only POS and NEG drive an upper switch.
   function automatic logic [1:0] igbt_of(input state_t st);
      case (st)
         ST_POS:  return IGBT_R;
         ST_NEG:  return IGBT_L;
         default: return IGBT_OFF;
      endcase
   endfunction

   function automatic logic is_running(input state_t st);
      return (st != ST_IDLE) && (st != ST_FAULT);
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase-length counter: counts 1..terminal, terminal clamped to at least 1.
// The count restarts at 1 whenever i_load is high.
module phase_timer
   import hbridge_seq_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_term,
   output logic             o_tc
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_term;
   logic             w_tc;

   assign w_term = (i_term == {CNT_W{1'b0}}) ? ONE : i_term;
   assign w_tc   = (r_cnt >= w_term);
   assign o_tc   = w_tc;

   // Count register; never passes the terminal value, so no wrap at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= ONE;
      end else if (i_load) begin
         r_cnt <= ONE;
      end else if (!w_tc) begin
         r_cnt <= r_cnt + ONE;
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/hbridge_seq.sv
// H-bridge switching sequencer: POS / dead / NEG / dead cycle with soft stop and latched fault.
// All outputs are registered from the next-state decode so they change on the transition edge.
module hbridge_seq
   import hbridge_seq_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_stop,
   input  logic             err_unit,
   input  logic             fault_clr,
   input  logic [CNT_W-1:0] half_per,
   input  logic [CNT_W-1:0] dead_t,
   output logic [1:0]       igbt_control,
   output logic             run_active,
   output logic             fault_latched,
   output logic             cycle_done
);

   state_t           r_state;
   state_t           w_next;
   logic             r_ss_d;
   logic [CNT_W-1:0] r_half;
   logic [CNT_W-1:0] r_dead;
   logic [1:0]       r_igbt;
   logic             r_run;
   logic             r_fault;
   logic             r_cyc_done;

   logic             w_rise;
   logic             w_tc;
   logic             w_load;
   logic             w_reload;
   logic             w_cyc_done;
   logic [CNT_W-1:0] w_term;

   assign w_rise = start_stop & ~r_ss_d;

   // Next-state decode; a fault overrides every other event.
   always_comb begin
      w_next = r_state;
      if (err_unit) begin
         w_next = ST_FAULT;
      end else begin
         case (r_state)
            ST_IDLE:   w_next = w_rise ? ST_POS : ST_IDLE;
            ST_POS:    w_next = w_tc ? ST_DEAD_P : ST_POS;
            ST_DEAD_P: w_next = w_tc ? ST_NEG : ST_DEAD_P;
            ST_NEG:    w_next = w_tc ? ST_DEAD_N : ST_NEG;
            ST_DEAD_N: begin
               if (w_tc) begin
                  w_next = start_stop ? ST_POS : ST_IDLE;
               end else begin
                  w_next = ST_DEAD_N;
               end
            end
            ST_FAULT:  w_next = fault_clr ? ST_IDLE : ST_FAULT;
            default:   w_next = ST_IDLE;
         endcase
      end
   end

   assign w_load     = (w_next != r_state) || !is_running(r_state);
   assign w_reload   = (w_next == ST_POS) &&
                       ((r_state == ST_IDLE) || (r_state == ST_DEAD_N));
   assign w_cyc_done = (r_state == ST_DEAD_N) &&
                       ((w_next == ST_POS) || (w_next == ST_IDLE));
   assign w_term     = ((r_state == ST_POS) || (r_state == ST_NEG)) ? r_half : r_dead;

   phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_term (w_term),
      .o_tc   (w_tc)
   );

   // State, start-edge history and shadow timing registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ss_d  <= 1'b1;
         r_half  <= {CNT_W{1'b0}};
         r_dead  <= {CNT_W{1'b0}};
      end else begin
         r_state <= w_next;
         r_ss_d  <= start_stop;
         if (w_reload) begin
            r_half <= half_per;
            r_dead <= dead_t;
         end else begin
            r_half <= r_half;
            r_dead <= r_dead;
         end
      end
   end

   // Output registers track the state being entered on this edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_igbt     <= IGBT_OFF;
         r_run      <= 1'b0;
         r_fault    <= 1'b0;
         r_cyc_done <= 1'b0;
      end else begin
         r_igbt     <= igbt_of(w_next);
         r_run      <= is_running(w_next);
         r_fault    <= (w_next == ST_FAULT);
         r_cyc_done <= w_cyc_done;
      end
   end

   assign igbt_control  = r_igbt;
   assign run_active    = r_run;
   assign fault_latched = r_fault;
   assign cycle_done    = r_cyc_done;

endmodule
